// File: rtl/pipe_pkg.sv
// Shared pipeline constants: per-stage bundle widths, control field offsets
// and the bubble pattern each stage presents when its output is empty.
package pipe_pkg;

   // Control bundle layout (bit offsets)
   localparam int CTRL_REGWRITE   = 0;
   localparam int CTRL_MEMTOREG   = 1;
   localparam int CTRL_MEMREAD    = 2;
   localparam int CTRL_MEMWRITE   = 3;
   localparam int CTRL_RDSRC      = 4;
   localparam int CTRL_ALUSRC     = 5;
   localparam int CTRL_PCTOREGSRC = 6;
   localparam int CTRL_ALUOP_LO   = 7;
   localparam int CTRL_ALUOP_HI   = 9;
   localparam int CTRL_FULL_W     = 10;

   // Per-stage widths; IF/ID carries PC + instruction, later stages shed fields
   localparam int IF_ID_CTRL_W  = 1;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = CTRL_FULL_W;
   localparam int ID_EX_DATA_W  = 32 * 4 + 5;
   localparam int EX_MEM_CTRL_W = CTRL_MEMWRITE + 1 + 1;
   localparam int EX_MEM_DATA_W = 32 * 3 + 5;
   localparam int MEM_WB_CTRL_W = CTRL_MEMTOREG + 1;
   localparam int MEM_WB_DATA_W = 32 * 2 + 5;

   // Bubbles clear every write/side-effect enable so an empty slot is harmless
   localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_BUBBLE  = '0;
   localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_BUBBLE  = '0;
   localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = '0;
   localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = '0;

   // Stage occupancy state; bit1 = main valid, bit0 = skid valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b10,
      ST_SKID  = 2'b11
   } stage_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle link between two pipeline stages.
// Handshake: a beat transfers on a rising edge where valid && ready; once valid
// is raised the sender holds ctrl/data stable until that transfer happens.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input ready);
   modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high, sticks at all-ones,
// cleared only by reset.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble
// and a saturating stall-cycle counter. in_ready comes straight from a flop.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                CTRL_W      = 8,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
   parameter int                CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   pipe_stage_skid_if.slave      in_if,
   pipe_stage_skid_if.master     out_if,
   output logic [1:0]            occupancy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [1:0]            state_dbg
);
   stage_state_e      state_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;

   logic main_valid;
   logic skid_valid;
   logic in_ready;
   logic in_fire;
   logic out_fire;

   assign main_valid = state_q[1];
   assign skid_valid = state_q[0];
   assign in_ready   = !skid_valid;
   assign in_fire    = in_if.valid && in_ready;
   assign out_fire   = main_valid && out_if.ready;

   // Data/ctrl registers load only on the handshake transitions below
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (flush) begin
         state_q <= ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_q     <= ST_FULL;
                  main_ctrl_q <= in_if.ctrl;
                  main_data_q <= in_if.data;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_ctrl_q <= in_if.ctrl;
                  main_data_q <= in_if.data;
               end else if (in_fire) begin
                  state_q     <= ST_SKID;
                  skid_ctrl_q <= in_if.ctrl;
                  skid_data_q <= in_if.data;
               end else if (out_fire) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_q     <= ST_FULL;
                  main_ctrl_q <= skid_ctrl_q;
                  main_data_q <= skid_data_q;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign in_if.ready  = in_ready;
   assign out_if.valid = main_valid;
   assign out_if.ctrl  = main_valid ? main_ctrl_q : CTRL_BUBBLE;
   assign out_if.data  = main_data_q;

   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
   assign state_dbg = state_q;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (main_valid && !out_if.ready),
      .count_o (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid fill/drain,
// flush and stall-counter saturation with a narrow counter.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int                DATA_W = 32;
   localparam int                CTRL_W = 8;
   localparam logic [CTRL_W-1:0] BUBBLE = 8'h81;
   localparam int                CNT_W  = 2;

   logic clk;
   logic rst;
   logic flush;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       state_dbg;

   int vectors;
   int miscompares;

   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

   pipe_stage_skid #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .CTRL_BUBBLE (BUBBLE),
      .CNT_W       (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_if     (up_if),
      .out_if    (dn_if),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
      up_if.valid = v;
      up_if.ctrl  = c;
      up_if.data  = d;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      flush       = 1'b0;
      dn_if.ready = 1'b0;
      drive(1'b1, 8'h77, 32'h99);

      // Reset held two cycles with a pending input
      step();
      step();
      check("rst_out_valid", 32'(dn_if.valid), 32'd0);
      check("rst_in_ready",  32'(up_if.ready), 32'd1);
      check("rst_occ",       32'(occupancy),   32'd0);
      check("rst_ctrl",      32'(dn_if.ctrl),  32'h81);
      check("rst_stall",     32'(stall_cnt),   32'd0);

      // Streaming with out_ready high
      rst = 1'b1;
      dn_if.ready = 1'b1;
      drive(1'b1, 8'h20, 32'h10);
      step();
      check("s0_valid", 32'(dn_if.valid), 32'd1);
      check("s0_data",  dn_if.data,       32'h10);
      check("s0_ctrl",  32'(dn_if.ctrl),  32'h20);
      check("s0_occ",   32'(occupancy),   32'd1);
      drive(1'b1, 8'h21, 32'h11);
      step();
      check("s1_data",  dn_if.data,       32'h11);
      check("s1_occ",   32'(occupancy),   32'd1);
      check("s1_ready", 32'(up_if.ready), 32'd1);
      drive(1'b1, 8'h22, 32'h12);
      step();
      check("s2_data",  dn_if.data,       32'h12);
      check("s2_ctrl",  32'(dn_if.ctrl),  32'h22);
      check("s2_occ",   32'(occupancy),   32'd1);
      drive(1'b0, 8'h00, 32'h0);
      step();
      check("s3_valid", 32'(dn_if.valid), 32'd0);
      check("s3_occ",   32'(occupancy),   32'd0);
      check("s3_ctrl",  32'(dn_if.ctrl),  32'h81);
      check("s3_stall", 32'(stall_cnt),   32'd0);

      // Skid fill then drain
      dn_if.ready = 1'b0;
      drive(1'b1, 8'h0A, 32'hA);
      step();
      check("k0_data",  dn_if.data,       32'hA);
      check("k0_occ",   32'(occupancy),   32'd1);
      check("k0_ready", 32'(up_if.ready), 32'd1);
      drive(1'b1, 8'h0B, 32'hB);
      step();
      check("k1_occ",   32'(occupancy),   32'd2);
      check("k1_ready", 32'(up_if.ready), 32'd0);
      check("k1_data",  dn_if.data,       32'hA);
      check("k1_ctrl",  32'(dn_if.ctrl),  32'h0A);
      check("k1_stall", 32'(stall_cnt),   32'd1);
      drive(1'b0, 8'h00, 32'h0);
      dn_if.ready = 1'b1;
      step();
      check("k2_data",  dn_if.data,       32'hB);
      check("k2_ctrl",  32'(dn_if.ctrl),  32'h0B);
      check("k2_occ",   32'(occupancy),   32'd1);
      check("k2_ready", 32'(up_if.ready), 32'd1);
      check("k2_stall", 32'(stall_cnt),   32'd1);
      step();
      check("k3_valid", 32'(dn_if.valid), 32'd0);
      check("k3_occ",   32'(occupancy),   32'd0);

      // Flush from SKID with a same-cycle input
      dn_if.ready = 1'b0;
      drive(1'b1, 8'h31, 32'hD1);
      step();
      drive(1'b1, 8'h32, 32'hD2);
      step();
      check("f0_occ",   32'(occupancy),   32'd2);
      check("f0_stall", 32'(stall_cnt),   32'd2);
      flush = 1'b1;
      drive(1'b1, 8'h0C, 32'hC);
      step();
      check("f1_valid", 32'(dn_if.valid), 32'd0);
      check("f1_occ",   32'(occupancy),   32'd0);
      check("f1_ctrl",  32'(dn_if.ctrl),  32'h81);
      check("f1_ready", 32'(up_if.ready), 32'd1);
      check("f1_stall", 32'(stall_cnt),   32'd3);
      flush = 1'b0;
      drive(1'b0, 8'h00, 32'h0);
      dn_if.ready = 1'b1;
      step();
      check("f2_valid", 32'(dn_if.valid), 32'd0);
      check("f2_occ",   32'(occupancy),   32'd0);

      // Stall counter saturation with a 2-bit counter
      rst = 1'b0;
      step();
      check("c_rst_stall", 32'(stall_cnt), 32'd0);
      rst = 1'b1;
      dn_if.ready = 1'b0;
      drive(1'b1, 8'h55, 32'h55);
      step();
      check("c_fill_stall", 32'(stall_cnt), 32'd0);
      drive(1'b0, 8'h00, 32'h0);
      step(); check("c1", 32'(stall_cnt), 32'd1);
      step(); check("c2", 32'(stall_cnt), 32'd2);
      step(); check("c3", 32'(stall_cnt), 32'd3);
      step(); check("c4", 32'(stall_cnt), 32'd3);
      step(); check("c5", 32'(stall_cnt), 32'd3);
      step(); check("c6", 32'(stall_cnt), 32'd3);
      check("c_hold_data", dn_if.data,      32'h55);
      check("c_hold_ctrl", 32'(dn_if.ctrl), 32'h55);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("c_flush_valid", 32'(dn_if.valid), 32'd0);
      check("c_flush_stall", 32'(stall_cnt),   32'd3);
      step();
      check("c_idle_stall", 32'(stall_cnt), 32'd3);

      // Reset overrides a same-cycle input and flush
      rst = 1'b0;
      flush = 1'b1;
      drive(1'b1, 8'h66, 32'h66);
      step();
      check("r_stall", 32'(stall_cnt),   32'd0);
      check("r_occ",   32'(occupancy),   32'd0);
      check("r_valid", 32'(dn_if.valid), 32'd0);
      check("r_ctrl",  32'(dn_if.ctrl),  32'h81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
